// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module  : regfile_pkg
// Brief   : Shared types and default sizes for the register file, decode and
//           writeback stages.
// Revision: 1.0 - initial release
// ============================================================================
package regfile_pkg;

    localparam int c_DATA_W = 32;
    localparam int c_ADDR_W = 5;
    localparam int c_DEPTH  = 32;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/regfile_read_port.sv
`default_nettype none
// ============================================================================
// Module  : regfile_read_port
// Brief   : One combinational read port with range, zero-register and bypass.
// Revision: 1.0 - initial release
// ============================================================================
module regfile_read_port #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int DEPTH    = 32,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              isClear,
    input  logic [ADDR_W-1:0] rdAddr,
    input  logic              wrAccept,
    input  logic [ADDR_W-1:0] wrAddr,
    input  logic [DATA_W-1:0] wrData,
    input  logic [DATA_W-1:0] mem [DEPTH],
    output logic [DATA_W-1:0] rdData
);

    // One extra bit so DEPTH == 2**ADDR_W is representable.
    localparam logic [ADDR_W:0] c_DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

    logic w_inRange;
    logic w_isZero;
    logic w_hit;

    assign w_inRange = ({1'b0, rdAddr} < c_DEPTH_EXT);
    assign w_isZero  = (ZERO_REG != 0) && (rdAddr == '0);
    assign w_hit     = (BYPASS != 0) && wrAccept && (wrAddr == rdAddr);

    always_comb begin
        rdData = '0;
        if (!isClear && w_inRange && !w_isZero) begin
            if (w_hit) begin
                rdData = wrData;
            end else begin
                rdData = mem[rdAddr];
            end
        end
    end

endmodule : regfile_read_port
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// Module  : regfile_mp
// Brief   : Multi-port register file with post-reset clear sequencer.
// Revision: 1.0 - initial release
// ============================================================================
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = c_DATA_W,
    parameter int ADDR_W   = c_ADDR_W,
    parameter int DEPTH    = c_DEPTH,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    output logic                     ready
);

    localparam int              c_PTR_W     = $clog2(DEPTH);
    localparam logic [c_PTR_W-1:0] c_LAST   = c_PTR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0] c_DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

    state_t               r_state;
    logic [c_PTR_W-1:0]   r_clrPtr;
    logic                 r_ready;
    logic [DATA_W-1:0]    r_mem [DEPTH];

    logic w_wrInRange;
    logic w_wrZero;
    logic w_wrAccept;

    assign w_wrInRange = ({1'b0, wr_addr} < c_DEPTH_EXT);
    assign w_wrZero    = (ZERO_REG != 0) && (wr_addr == '0);
    assign w_wrAccept  = (r_state == RUN) && wr_en && !reset && w_wrInRange && !w_wrZero;

    // Storage is deliberately left untouched by reset; the CLEAR walk zeroes it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= CLEAR;
            r_clrPtr <= '0;
            r_ready  <= 1'b0;
        end else begin
            case (r_state)
                CLEAR: begin
                    r_mem[r_clrPtr] <= '0;
                    r_clrPtr        <= r_clrPtr + 1'b1;
                    if (r_clrPtr == c_LAST) begin
                        r_state <= RUN;
                        r_ready <= 1'b1;
                    end
                end
                RUN: begin
                    if (w_wrAccept) begin
                        r_mem[wr_addr] <= wr_data;
                    end
                end
                default: begin
                    r_state <= CLEAR;
                end
            endcase
        end
    end

    assign ready = r_ready;

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rdPort
        regfile_read_port #(
            .DATA_W  (DATA_W),
            .ADDR_W  (ADDR_W),
            .DEPTH   (DEPTH),
            .ZERO_REG(ZERO_REG),
            .BYPASS  (BYPASS)
        ) u_port (
            .isClear (r_state == CLEAR),
            .rdAddr  (rd_addr[i*ADDR_W +: ADDR_W]),
            .wrAccept(w_wrAccept),
            .wrAddr  (wr_addr),
            .wrData  (wr_data),
            .mem     (r_mem),
            .rdData  (rd_data[i*DATA_W +: DATA_W])
        );
    end

endmodule : regfile_mp
`default_nettype wire
